// File: rtl/up_down_counter_pkg.sv
// -----------------------------------------------------------------------------
// up_down_counter_pkg
//   Shared types and constants for the up_down_counter block.
//   - udc_op_e          : priority-decoded operation applied at the next edge
//   - UDC_DEFAULT_WIDTH : default counter width
//   - UDC_MIN_WIDTH     : smallest legal counter width
// Configuration macro used by the block: UDC_WRAP_EN (see udc_next_value).
// -----------------------------------------------------------------------------
package up_down_counter_pkg;

  typedef enum logic [1:0] {
    UDC_HOLD = 2'd0,
    UDC_LOAD = 2'd1,
    UDC_DEC  = 2'd2,
    UDC_INC  = 2'd3
  } udc_op_e;

  localparam int UDC_DEFAULT_WIDTH = 5;
  localparam int UDC_MIN_WIDTH     = 2;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter_next_value.sv
// -----------------------------------------------------------------------------
// udc_next_value
//   Purely combinational next-count calculation for up_down_counter.
//   Configuration: `define UDC_WRAP_EN for modulo arithmetic (max+1 -> 0,
//   0-1 -> max); default build saturates at both ends.
// Ports:
//   i_count   in   DATA_WIDTH  current counter register value
//   i_op      in   udc_op_e    priority-decoded operation
//   i_in      in   DATA_WIDTH  parallel load value
//   o_next    out  DATA_WIDTH  value to write when o_update is high
//   o_update  out  1           1 when the register must take o_next; 0 for
//                              hold, including a saturated boundary step
// -----------------------------------------------------------------------------
module udc_next_value
  import up_down_counter_pkg::*;
#(
  parameter int DATA_WIDTH = UDC_DEFAULT_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_count,
  input  udc_op_e               i_op,
  input  logic [DATA_WIDTH-1:0] i_in,
  output logic [DATA_WIDTH-1:0] o_next,
  output logic                  o_update
);

  localparam logic [DATA_WIDTH-1:0] C_MAX  = '1;
  localparam logic [DATA_WIDTH-1:0] C_ZERO = '0;

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    o_next   = i_count;
    o_update = 1'b0;
    case (i_op)
      UDC_LOAD: begin
        o_next   = i_in;
        o_update = 1'b1;
      end
      UDC_DEC: begin
        if (i_count == C_ZERO) begin
`ifdef UDC_WRAP_EN
          o_next   = C_MAX;
          o_update = 1'b1;
`endif
        end else begin
          o_next   = i_count - 1'b1;
          o_update = 1'b1;
        end
      end
      UDC_INC: begin
        if (i_count == C_MAX) begin
`ifdef UDC_WRAP_EN
          o_next   = C_ZERO;
          o_update = 1'b1;
`endif
        end else begin
          o_next   = i_count + 1'b1;
          o_update = 1'b1;
        end
      end
      default: begin
        o_next   = i_count;
        o_update = 1'b0;
      end
    endcase
  end

endmodule : udc_next_value

// File: rtl/up_down_counter.sv
// -----------------------------------------------------------------------------
// up_down_counter
//   Loadable up/down binary counter with all-ones / zero flags.
//   Priority per rising edge: load > down > up > hold. Saturates at both ends
//   unless built with `define UDC_WRAP_EN, which selects modulo arithmetic.
// Ports:
//   i_clk      in   1           rising-edge clock
//   i_rst_n    in   1           asynchronous active-low reset
//   i_in       in   DATA_WIDTH  parallel load value
//   i_load     in   1           load i_in
//   i_up       in   1           increment request
//   i_down     in   1           decrement request (beats i_up)
//   o_counter  out  DATA_WIDTH  registered count
//   o_low      out  1           count == 0
//   o_high     out  1           count == all ones
// -----------------------------------------------------------------------------
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int DATA_WIDTH = UDC_DEFAULT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_in,
  input  logic                  i_load,
  input  logic                  i_up,
  input  logic                  i_down,
  output logic [DATA_WIDTH-1:0] o_counter,
  output logic                  o_low,
  output logic                  o_high
);

  logic [DATA_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0] w_next;
  logic                  w_update;
  udc_op_e               w_op;

  // Priority decode. An unknown request falls through to a lower-priority
  // branch (ultimately hold), so the operation is always a legal encoding and
  // the register never captures X.
  always_comb begin
    w_op = UDC_HOLD;
    if (i_load) begin
      w_op = UDC_LOAD;
    end else if (i_down) begin
      w_op = UDC_DEC;
    end else if (i_up) begin
      w_op = UDC_INC;
    end
  end

  udc_next_value #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_next_value (
    .i_count  (r_count),
    .i_op     (w_op),
    .i_in     (i_in),
    .o_next   (w_next),
    .o_update (w_update)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (w_update) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values, independent of process ordering.
      r_count <= w_next;
    end
  end

  // Flags decode the register directly, so they move with o_counter and
  // follow reset asynchronously. Zero and all-ones are distinct for width >= 2.
  assign o_counter = r_count;
  assign o_low     = (r_count == '0);
  assign o_high    = (r_count == '1);

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// -----------------------------------------------------------------------------
// tb_up_down_counter
//   Self-checking bench for up_down_counter (DATA_WIDTH = 5). Expected values
//   come from an arithmetic reference model of the counting rules; define
//   UDC_WRAP_EN for both bench and RTL to check the modulo variant.
// -----------------------------------------------------------------------------
module tb_up_down_counter;

  localparam int W   = 5;
  localparam int MAX = (1 << W) - 1;
`ifdef UDC_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic [W-1:0] i_in;
  logic         i_load;
  logic         i_up;
  logic         i_down;
  logic [W-1:0] o_counter;
  logic         o_low;
  logic         o_high;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt   = 0;   // reference model count

  up_down_counter #(.DATA_WIDTH(W)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_in      (i_in),
    .i_load    (i_load),
    .i_up      (i_up),
    .i_down    (i_down),
    .o_counter (o_counter),
    .o_low     (o_low),
    .o_high    (o_high)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: one clock step of the counting rules.
  function automatic int model_next(int c, bit ld, bit up, bit dn, int v);
    if (ld) return v;
    if (dn) return (c == 0)   ? (WRAP ? MAX : 0) : c - 1;
    if (up) return (c == MAX) ? (WRAP ? 0 : MAX) : c + 1;
    return c;
  endfunction

  // Advance model and DUT by one rising edge; returns 1 ns after the edge.
  task automatic tick();
    m_cnt = model_next(m_cnt, i_load, i_up, i_down, int'(i_in));
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(bit ld, bit up, bit dn, int v);
    i_load = ld;
    i_up   = up;
    i_down = dn;
    i_in   = W'(v);
  endtask

  task automatic test_reset();
    // Reset held from time zero.
    #2;
    n_tests++;
    if ({o_counter, o_low, o_high} !== {W'(0), 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_initial: got cnt=%0d low=%b high=%b want cnt=0 low=1 high=0",
               o_counter, o_low, o_high);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    m_cnt   = 0;
    drive(1, 0, 0, 12);
    tick();
    n_tests++;
    if (o_counter !== W'(12)) begin
      n_fail++;
      $display("FAIL reset_preload: got %0d want 12", o_counter);
    end
    // Assert reset mid-cycle and check before any clock edge.
    #3;
    i_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_counter, o_low, o_high} !== {W'(0), 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got cnt=%0d low=%b high=%b want cnt=0 low=1 high=0",
               o_counter, o_low, o_high);
    end
    // Reset dominates load across an edge.
    tick();
    m_cnt = 0;
    n_tests++;
    if (o_counter !== W'(0)) begin
      n_fail++;
      $display("FAIL reset_dominates: got %0d want 0", o_counter);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive(0, 0, 0, 0);
  endtask

  task automatic test_load();
    drive(1, 1, 0, 7);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (o_counter !== W'(7)) begin
        n_fail++;
        $display("FAIL load_hold[%0d]: got %0d want 7", i, o_counter);
      end
    end
    drive(0, 1, 0, 7);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (o_counter !== W'(8 + i)) begin
        n_fail++;
        $display("FAIL load_then_up[%0d]: got %0d want %0d", i, o_counter, 8 + i);
      end
    end
  endtask

  task automatic test_count_up();
    drive(1, 0, 0, 7);
    tick();
    drive(0, 1, 0, 0);
    for (int i = 0; i < 24; i++) begin
      tick();
      n_tests++;
      if (o_counter !== W'(m_cnt)) begin
        n_fail++;
        $display("FAIL count_up[%0d]: got %0d want %0d", i, o_counter, m_cnt);
      end
    end
    n_tests++;
    if ({o_counter, o_low, o_high} !== {W'(31), 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL count_up_max: got cnt=%0d low=%b high=%b want cnt=31 low=0 high=1",
               o_counter, o_low, o_high);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({o_counter, o_low, o_high} !== {W'(m_cnt), m_cnt == 0, m_cnt == MAX}) begin
        n_fail++;
        $display("FAIL count_up_past_max[%0d]: got cnt=%0d low=%b high=%b want cnt=%0d",
                 i, o_counter, o_low, o_high, m_cnt);
      end
    end
  endtask

  task automatic test_count_down();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    i_rst_n = 1'b1;
    m_cnt   = 0;
    drive(1, 0, 0, 7);
    tick();
    drive(0, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      n_tests++;
      if (o_counter !== W'(6 - i)) begin
        n_fail++;
        $display("FAIL count_down[%0d]: got %0d want %0d", i, o_counter, 6 - i);
      end
    end
    n_tests++;
    if ({o_counter, o_low, o_high} !== {W'(0), 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL count_down_zero: got cnt=%0d low=%b high=%b want cnt=0 low=1 high=0",
               o_counter, o_low, o_high);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({o_counter, o_low, o_high} !== {W'(m_cnt), m_cnt == 0, m_cnt == MAX}) begin
        n_fail++;
        $display("FAIL count_down_past_zero[%0d]: got cnt=%0d low=%b high=%b want cnt=%0d",
                 i, o_counter, o_low, o_high, m_cnt);
      end
    end
  endtask

  task automatic test_priority();
    drive(1, 0, 0, 10);
    tick();
    drive(0, 1, 1, 0);
    tick();
    n_tests++;
    if (o_counter !== W'(9)) begin
      n_fail++;
      $display("FAIL priority_down_over_up: got %0d want 9", o_counter);
    end
    drive(1, 1, 1, 20);
    tick();
    n_tests++;
    if (o_counter !== W'(20)) begin
      n_fail++;
      $display("FAIL priority_load_first: got %0d want 20", o_counter);
    end
  endtask

  task automatic test_unknown_request();
    drive(1, 0, 0, 5);
    tick();
    i_load = 1'b0;
    i_down = 1'b0;
    i_up   = 1'bx;
    @(posedge i_clk);
    #1;
    n_tests++;
    if ($isunknown({o_counter, o_low, o_high})) begin
      n_fail++;
      $display("FAIL unknown_request: got cnt=%b low=%b high=%b want no X",
               o_counter, o_low, o_high);
    end
    // Re-synchronise the model with a known load.
    drive(1, 0, 0, 5);
    tick();
  endtask

  task automatic test_reset_mid_count();
    drive(1, 0, 0, 14);
    tick();
    drive(0, 1, 0, 0);
    tick();
    n_tests++;
    if (o_counter !== W'(15)) begin
      n_fail++;
      $display("FAIL midreset_pre: got %0d want 15", o_counter);
    end
    #3;
    i_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_counter, o_low, o_high} !== {W'(0), 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_async: got cnt=%0d low=%b high=%b want cnt=0 low=1 high=0",
               o_counter, o_low, o_high);
    end
    #2;
    i_rst_n = 1'b1;
    m_cnt   = 0;
    tick();
    n_tests++;
    if (o_counter !== W'(1)) begin
      n_fail++;
      $display("FAIL midreset_resume: got %0d want 1", o_counter);
    end
  endtask

  task automatic test_random();
    bit up_heavy;
    for (int blk = 0; blk < 8; blk++) begin
      up_heavy = blk[0];
      for (int i = 0; i < 50; i++) begin
        i_load = ($urandom_range(0, 11) == 0);
        i_in   = W'($urandom_range(0, MAX));
        if (up_heavy) begin
          i_up   = ($urandom_range(0, 3) != 0);
          i_down = ($urandom_range(0, 5) == 0);
        end else begin
          i_up   = ($urandom_range(0, 5) == 0);
          i_down = ($urandom_range(0, 3) != 0);
        end
        tick();
        n_tests++;
        if ({o_counter, o_low, o_high} !== {W'(m_cnt), m_cnt == 0, m_cnt == MAX}) begin
          n_fail++;
          $display("FAIL random[%0d.%0d]: got cnt=%0d low=%b high=%b want cnt=%0d low=%b high=%b",
                   blk, i, o_counter, o_low, o_high, m_cnt, m_cnt == 0, m_cnt == MAX);
        end
      end
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    drive(0, 0, 0, 0);
    test_reset();
    test_load();
    test_count_up();
    test_count_down();
    test_priority();
    test_unknown_request();
    test_reset_mid_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_up_down_counter
